// File: rtl/arbitro_vc_ponderado.sv
// arbitro_vc_ponderado: weighted arbiter/router between two virtual-channel
// FIFOs (VC0, VC1) and two destination FIFOs (D0, D1). VC0 may take up to
// PESO_VC0 consecutive grants while VC1 is also eligible. The granted head is
// popped combinationally and pushed into its destination one cycle later.
module arbitro_vc_ponderado #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int PESO_VC0   = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] VC0,
    input  logic [DATA_WIDTH-1:0] VC1,
    input  logic                  VC0_empty,
    input  logic                  VC1_empty,
    input  logic                  D0_pause,
    input  logic                  D1_pause,
    output logic                  VC0_pop,
    output logic                  VC1_pop,
    output logic [DATA_WIDTH-1:0] D0_out,
    output logic [DATA_WIDTH-1:0] D1_out,
    output logic                  D0_push,
    output logic                  D1_push,
    output logic [1:0]            estado,
    output logic [CNT_W-1:0]      cuenta_D0,
    output logic [CNT_W-1:0]      cuenta_D1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVO    = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    localparam logic [3:0] PESO_W = 4'(PESO_VC0);

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic [DATA_WIDTH-1:0] palabra_s;

    logic [3:0]            cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] d0_out_q,    d0_out_d;
    logic [DATA_WIDTH-1:0] d1_out_q,    d1_out_d;
    logic                  d0_push_q,   d0_push_d;
    logic                  d1_push_q,   d1_push_d;
    logic [CNT_W-1:0]      cuenta0_q,   cuenta0_d;
    logic [CNT_W-1:0]      cuenta1_q,   cuenta1_d;
    estado_t               estado_q,    estado_d;

    // Eligibility: a head is eligible when present and its own destination is not paused.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        if (VC0[DEST_BIT]) begin
            elig0_s = !VC0_empty && !D1_pause;
        end else begin
            elig0_s = !VC0_empty && !D0_pause;
        end
        if (VC1[DEST_BIT]) begin
            elig1_s = !VC1_empty && !D1_pause;
        end else begin
            elig1_s = !VC1_empty && !D0_pause;
        end
    end

    // Weighted grant selection and weight counter update.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        cnt_d  = cnt_q;
        if (elig0_s && elig1_s) begin
            if (cnt_q < PESO_W) begin
                gnt0_s = 1'b1;
                cnt_d  = cnt_q + 4'd1;
            end else begin
                gnt1_s = 1'b1;
                cnt_d  = 4'd0;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
            // Saturate so a late-arriving VC1 is not starved by a long VC0-only run.
            if (cnt_q < PESO_W) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d = PESO_W;
            end
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
            cnt_d  = 4'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pops are suppressed while reset is held so no word is consumed and then discarded.
    assign VC0_pop = gnt0_s & reset_L;
    assign VC1_pop = gnt1_s & reset_L;

    // Route the granted word, update push pulses, counters and next FSM state.
    always_comb begin
        d0_out_d  = d0_out_q;
        d1_out_d  = d1_out_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        cuenta0_d = cuenta0_q;
        cuenta1_d = cuenta1_q;
        estado_d  = estado_q;
        if (gnt0_s) begin
            palabra_s = VC0;
        end else begin
            palabra_s = VC1;
        end
        if (gnt0_s || gnt1_s) begin
            if (palabra_s[DEST_BIT]) begin
                d1_out_d  = palabra_s;
                d1_push_d = 1'b1;
                cuenta1_d = cuenta1_q + CNT_W'(1);
            end else begin
                d0_out_d  = palabra_s;
                d0_push_d = 1'b1;
                cuenta0_d = cuenta0_q + CNT_W'(1);
            end
        end else begin
            d0_push_d = 1'b0;
        end
        if (gnt0_s || gnt1_s) begin
            estado_d = ACTIVO;
        end else if (!VC0_empty || !VC1_empty) begin
            estado_d = BLOQUEADO;
        end else begin
            estado_d = IDLE;
        end
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_q     <= 4'd0;
            d0_out_q  <= '0;
            d1_out_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            cuenta0_q <= '0;
            cuenta1_q <= '0;
            estado_q  <= IDLE;
        end else begin
            cnt_q     <= cnt_d;
            d0_out_q  <= d0_out_d;
            d1_out_q  <= d1_out_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            cuenta0_q <= cuenta0_d;
            cuenta1_q <= cuenta1_d;
            estado_q  <= estado_d;
        end
    end

    assign D0_out    = d0_out_q;
    assign D1_out    = d1_out_q;
    assign D0_push   = d0_push_q;
    assign D1_push   = d1_push_q;
    assign cuenta_D0 = cuenta0_q;
    assign cuenta_D1 = cuenta1_q;
    assign estado    = estado_q;

endmodule
